// File: rtl/a1_ptr_step.sv
// a1_ptr_step: A1 window pointer stepper for the blitter address path.
// Walks a 16.16 X/Y pointer over an inner-by-outer pixel rectangle.
module a1_ptr_step (
  input  logic        clk,
  input  logic        resetl,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] pos_x_in,
  input  logic [15:0] pos_y_in,
  input  logic [15:0] pos_fx_in,
  input  logic [15:0] pos_fy_in,
  input  logic [15:0] inc_x,
  input  logic [15:0] inc_y,
  input  logic [15:0] inc_fx,
  input  logic [15:0] inc_fy,
  input  logic [15:0] step_x,
  input  logic [15:0] step_y,
  input  logic [15:0] step_fx,
  input  logic [15:0] step_fy,
  input  logic [15:0] inner_cnt,
  input  logic [15:0] outer_cnt,
  input  logic        pix_adv,
  output logic [15:0] a1_x,
  output logic [15:0] a1_y,
  output logic [15:0] a1_fx,
  output logic [15:0] a1_fy,
  output logic        pix_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LINE,
    S_FIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_px;
  logic [31:0] r_py;
  logic [15:0] r_icnt;
  logic [15:0] r_ocnt;
  logic [15:0] r_inner;
  logic        r_pix_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_is_idle;
  logic        w_is_run;
  logic        w_is_line;
  logic        w_load;
  logic        w_zero;
  logic        w_adv;
  logic        w_last_pix;
  logic        w_last_line;
  logic [31:0] w_add_x;
  logic [31:0] w_add_y;
  logic [31:0] w_sum_x;
  logic [31:0] w_sum_y;

  assign w_is_idle   = (r_state == S_IDLE);
  assign w_is_run    = (r_state == S_RUN);
  assign w_is_line   = (r_state == S_LINE);
  assign w_load      = w_is_idle & start & ~abort;
  assign w_zero      = (inner_cnt == 16'd0) | (outer_cnt == 16'd0);
  assign w_adv       = w_is_run & pix_adv & ~abort;
  assign w_last_pix  = (r_icnt == 16'd1);
  assign w_last_line = (r_ocnt == 16'd1);

  // Pick the pixel increment in RUN and the line step in LINE.
  always_comb begin
    w_add_x = {inc_x, inc_fx};
    w_add_y = {inc_y, inc_fy};
    if (w_is_line) begin
      w_add_x = {step_x, step_fx};
      w_add_y = {step_y, step_fy};
    end
  end

  // Full 32-bit adds so the fraction carries into the integer part.
  assign w_sum_x = r_px + w_add_x;
  assign w_sum_y = r_py + w_add_y;

  // Pointer: load on start, advance per pixel and per line.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_px <= 32'd0;
      r_py <= 32'd0;
    end else if (!abort) begin
      if (w_load) begin
        r_px <= {pos_x_in, pos_fx_in};
        r_py <= {pos_y_in, pos_fy_in};
      end else if (w_adv || w_is_line) begin
        r_px <= w_sum_x;
        r_py <= w_sum_y;
      end
    end
  end

  // Pixel and line counters, with the inner count kept for reloads.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_icnt  <= 16'd0;
      r_ocnt  <= 16'd0;
      r_inner <= 16'd0;
    end else if (!abort) begin
      if (w_load) begin
        r_icnt  <= inner_cnt;
        r_ocnt  <= outer_cnt;
        r_inner <= inner_cnt;
      end else if (w_adv) begin
        r_icnt <= r_icnt - 16'd1;
      end else if (w_is_line) begin
        r_icnt <= r_inner;
        r_ocnt <= r_ocnt - 16'd1;
      end
    end
  end

  // Walk sequencer with registered status outputs.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state     <= S_IDLE;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_zero) begin
              r_state     <= S_FIN;
              r_pix_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_pix_valid <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (pix_adv && w_last_pix) begin
            r_state     <= S_LINE;
            r_pix_valid <= 1'b0;
          end
        end
        S_LINE: begin
          if (w_last_line) begin
            r_state     <= S_FIN;
            r_pix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_state     <= S_RUN;
            r_pix_valid <= 1'b1;
          end
        end
        S_FIN: begin
          r_state     <= S_IDLE;
          r_pix_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_pix_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign a1_x      = r_px[31:16];
  assign a1_fx     = r_px[15:0];
  assign a1_y      = r_py[31:16];
  assign a1_fy     = r_py[15:0];
  assign pix_valid = r_pix_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_a1_ptr_step.sv
// tb_a1_ptr_step: directed bench for the A1 pointer stepper.
// Table of walks plus hand-written reset, stall, abort and zero-count cases.
module tb_a1_ptr_step;

  logic        clk;
  logic        resetl;
  logic        start;
  logic        abort;
  logic [15:0] pos_x_in, pos_y_in, pos_fx_in, pos_fy_in;
  logic [15:0] inc_x, inc_y, inc_fx, inc_fy;
  logic [15:0] step_x, step_y, step_fx, step_fy;
  logic [15:0] inner_cnt, outer_cnt;
  logic        pix_adv;
  logic [15:0] a1_x, a1_y, a1_fx, a1_fy;
  logic        pix_valid, busy, done;

  a1_ptr_step dut (
    .clk       (clk),
    .resetl    (resetl),
    .start     (start),
    .abort     (abort),
    .pos_x_in  (pos_x_in),
    .pos_y_in  (pos_y_in),
    .pos_fx_in (pos_fx_in),
    .pos_fy_in (pos_fy_in),
    .inc_x     (inc_x),
    .inc_y     (inc_y),
    .inc_fx    (inc_fx),
    .inc_fy    (inc_fy),
    .step_x    (step_x),
    .step_y    (step_y),
    .step_fx   (step_fx),
    .step_fy   (step_fy),
    .inner_cnt (inner_cnt),
    .outer_cnt (outer_cnt),
    .pix_adv   (pix_adv),
    .a1_x      (a1_x),
    .a1_y      (a1_y),
    .a1_fx     (a1_fx),
    .a1_fy     (a1_fy),
    .pix_valid (pix_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      px, py, ix, iy, sx, sy;
    logic [15:0]      ni, no;
    int               npix;
    int               cycles;
    logic [7:0][31:0] ex;
    logic [7:0][31:0] ey;
    logic [31:0]      fx, fy;
  } vec_t;

  vec_t tbl[6];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    pos_x_in  = v.px[31:16];
    pos_fx_in = v.px[15:0];
    pos_y_in  = v.py[31:16];
    pos_fy_in = v.py[15:0];
    inc_x     = v.ix[31:16];
    inc_fx    = v.ix[15:0];
    inc_y     = v.iy[31:16];
    inc_fy    = v.iy[15:0];
    step_x    = v.sx[31:16];
    step_fx   = v.sx[15:0];
    step_y    = v.sy[31:16];
    step_fy   = v.sy[15:0];
    inner_cnt = v.ni;
    outer_cnt = v.no;
  endtask

  // Cycles are counted with the start cycle as cycle 1.
  task automatic run_walk(input vec_t v, input int id);
    int k;
    int cyc;
    bit fin;
    set_cfg(v);
    start   = 1'b1;
    pix_adv = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 2;
    k   = 0;
    fin = 0;
    chk($sformatf("w%0d_busy_first", id), {63'd0, busy},
        {63'd0, (v.npix != 0)});
    while (!fin) begin
      if (pix_valid) begin
        if (k < 8 && k < v.npix) begin
          chk($sformatf("w%0d_px%0d", id, k), {32'd0, a1_x, a1_fx},
              {32'd0, v.ex[k]});
          chk($sformatf("w%0d_py%0d", id, k), {32'd0, a1_y, a1_fy},
              {32'd0, v.ey[k]});
        end
        k++;
      end
      if (done) begin
        fin = 1;
      end else if (cyc >= 200) begin
        chk($sformatf("w%0d_timeout", id), 64'(cyc), 64'(v.cycles));
        fin = 1;
      end else begin
        @(posedge clk);
        #1 cyc++;
      end
    end
    chk($sformatf("w%0d_cycles", id), 64'(cyc), 64'(v.cycles));
    chk($sformatf("w%0d_npix", id), 64'(k), 64'(v.npix));
    chk($sformatf("w%0d_final", id), {a1_x, a1_fx, a1_y, a1_fy},
        {v.fx, v.fy});
    pix_adv = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("w%0d_after", id),
        {a1_x, a1_fx, a1_y, a1_fy[15:3], done, busy, pix_valid},
        {v.fx, v.fy[31:3], 3'b000});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;

    // 3x2 walk
    tbl[0].px = 32'h000A_0000; tbl[0].py = 32'h0014_0000;
    tbl[0].ix = 32'h0001_0000; tbl[0].iy = 32'h0000_0000;
    tbl[0].sx = 32'hFFFD_0000; tbl[0].sy = 32'h0001_0000;
    tbl[0].ni = 16'd3; tbl[0].no = 16'd2;
    tbl[0].npix = 6; tbl[0].cycles = 10;
    tbl[0].ex = '0; tbl[0].ey = '0;
    tbl[0].ex[0] = 32'h000A_0000; tbl[0].ey[0] = 32'h0014_0000;
    tbl[0].ex[1] = 32'h000B_0000; tbl[0].ey[1] = 32'h0014_0000;
    tbl[0].ex[2] = 32'h000C_0000; tbl[0].ey[2] = 32'h0014_0000;
    tbl[0].ex[3] = 32'h000A_0000; tbl[0].ey[3] = 32'h0015_0000;
    tbl[0].ex[4] = 32'h000B_0000; tbl[0].ey[4] = 32'h0015_0000;
    tbl[0].ex[5] = 32'h000C_0000; tbl[0].ey[5] = 32'h0015_0000;
    tbl[0].fx = 32'h000A_0000; tbl[0].fy = 32'h0016_0000;

    // fraction carry, 4x1
    tbl[1].px = 32'h0000_C000; tbl[1].py = 32'h0000_0000;
    tbl[1].ix = 32'h0000_4000; tbl[1].iy = 32'h0000_0000;
    tbl[1].sx = 32'h0000_0000; tbl[1].sy = 32'h0000_0000;
    tbl[1].ni = 16'd4; tbl[1].no = 16'd1;
    tbl[1].npix = 4; tbl[1].cycles = 7;
    tbl[1].ex = '0; tbl[1].ey = '0;
    tbl[1].ex[0] = 32'h0000_C000;
    tbl[1].ex[1] = 32'h0001_0000;
    tbl[1].ex[2] = 32'h0001_4000;
    tbl[1].ex[3] = 32'h0001_8000;
    tbl[1].fx = 32'h0001_C000; tbl[1].fy = 32'h0000_0000;

    // negative wrap, 3x1
    tbl[2].px = 32'h0001_0000; tbl[2].py = 32'h0005_0000;
    tbl[2].ix = 32'hFFFF_0000; tbl[2].iy = 32'h0000_0000;
    tbl[2].sx = 32'h0000_0000; tbl[2].sy = 32'h0000_0000;
    tbl[2].ni = 16'd3; tbl[2].no = 16'd1;
    tbl[2].npix = 3; tbl[2].cycles = 6;
    tbl[2].ex = '0; tbl[2].ey = '0;
    tbl[2].ex[0] = 32'h0001_0000; tbl[2].ey[0] = 32'h0005_0000;
    tbl[2].ex[1] = 32'h0000_0000; tbl[2].ey[1] = 32'h0005_0000;
    tbl[2].ex[2] = 32'hFFFF_0000; tbl[2].ey[2] = 32'h0005_0000;
    tbl[2].fx = 32'hFFFE_0000; tbl[2].fy = 32'h0005_0000;

    // 2x3 with fractional step on Y and borrow-back on X
    tbl[3].px = 32'h0000_8000; tbl[3].py = 32'h0064_0000;
    tbl[3].ix = 32'h0000_8000; tbl[3].iy = 32'h0000_0000;
    tbl[3].sx = 32'hFFFF_0000; tbl[3].sy = 32'h0000_8000;
    tbl[3].ni = 16'd2; tbl[3].no = 16'd3;
    tbl[3].npix = 6; tbl[3].cycles = 11;
    tbl[3].ex = '0; tbl[3].ey = '0;
    tbl[3].ex[0] = 32'h0000_8000; tbl[3].ey[0] = 32'h0064_0000;
    tbl[3].ex[1] = 32'h0001_0000; tbl[3].ey[1] = 32'h0064_0000;
    tbl[3].ex[2] = 32'h0000_8000; tbl[3].ey[2] = 32'h0064_8000;
    tbl[3].ex[3] = 32'h0001_0000; tbl[3].ey[3] = 32'h0064_8000;
    tbl[3].ex[4] = 32'h0000_8000; tbl[3].ey[4] = 32'h0065_0000;
    tbl[3].ex[5] = 32'h0001_0000; tbl[3].ey[5] = 32'h0065_0000;
    tbl[3].fx = 32'h0000_8000; tbl[3].fy = 32'h0065_8000;

    // zero outer count
    tbl[4].px = 32'h1234_5678; tbl[4].py = 32'hABCD_0001;
    tbl[4].ix = 32'h0001_0000; tbl[4].iy = 32'h0001_0000;
    tbl[4].sx = 32'h0001_0000; tbl[4].sy = 32'h0001_0000;
    tbl[4].ni = 16'd5; tbl[4].no = 16'd0;
    tbl[4].npix = 0; tbl[4].cycles = 2;
    tbl[4].ex = '0; tbl[4].ey = '0;
    tbl[4].fx = 32'h1234_5678; tbl[4].fy = 32'hABCD_0001;

    // 2x2 with negative fractional Y increment
    tbl[5].px = 32'h0000_0000; tbl[5].py = 32'h0000_0000;
    tbl[5].ix = 32'h0001_0000; tbl[5].iy = 32'hFFFF_8000;
    tbl[5].sx = 32'hFFFE_0000; tbl[5].sy = 32'h0001_0000;
    tbl[5].ni = 16'd2; tbl[5].no = 16'd2;
    tbl[5].npix = 4; tbl[5].cycles = 8;
    tbl[5].ex = '0; tbl[5].ey = '0;
    tbl[5].ex[0] = 32'h0000_0000; tbl[5].ey[0] = 32'h0000_0000;
    tbl[5].ex[1] = 32'h0001_0000; tbl[5].ey[1] = 32'hFFFF_8000;
    tbl[5].ex[2] = 32'h0000_0000; tbl[5].ey[2] = 32'h0000_0000;
    tbl[5].ex[3] = 32'h0001_0000; tbl[5].ey[3] = 32'hFFFF_8000;
    tbl[5].fx = 32'h0000_0000; tbl[5].fy = 32'h0000_0000;

    resetl  = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pix_adv = 1'b0;
    set_cfg(tbl[0]);
    #12;
    chk("reset_ptr", {a1_x, a1_fx, a1_y, a1_fy}, 64'd0);
    chk("reset_flags", {61'd0, pix_valid, busy, done}, 64'd0);
    @(negedge clk);
    resetl = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_walk(tbl[i], i);
    end

    // reset mid-walk
    set_cfg(tbl[0]);
    start   = 1'b1;
    pix_adv = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 resetl = 1'b0;
    #1;
    chk("midrst_ptr", {a1_x, a1_fx, a1_y, a1_fy}, 64'd0);
    chk("midrst_flags", {61'd0, pix_valid, busy, done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetl = 1'b1;
    ok = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (pix_valid || busy || done || a1_x != 16'd0) ok = 0;
    end
    chk("midrst_idle", {63'd0, ok}, 64'd1);
    pix_adv = 1'b0;

    // start and abort together in IDLE
    pos_x_in = 16'd77;
    start    = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("startabort_flags", {61'd0, pix_valid, busy, done}, 64'd0);
    chk("startabort_ptr", {48'd0, a1_x}, 64'd0);

    // stall, ignored start, abort
    pos_x_in  = 16'd50;  pos_fx_in = 16'd0;
    pos_y_in  = 16'd7;   pos_fy_in = 16'd0;
    inc_x     = 16'd2;   inc_fx    = 16'd0;
    inc_y     = 16'd0;   inc_fy    = 16'd0;
    step_x    = 16'd0;   step_fx   = 16'd0;
    step_y    = 16'd1;   step_fy   = 16'd0;
    inner_cnt = 16'd4;   outer_cnt = 16'd2;
    start   = 1'b1;
    pix_adv = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("stall_load", {48'd0, a1_x}, 64'd50);
    repeat (2) @(posedge clk);
    #1 pix_adv = 1'b0;
    chk("stall_pre", {48'd0, a1_x}, 64'd54);
    ok = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (a1_x != 16'd54 || a1_y != 16'd7 || !pix_valid || !busy) ok = 0;
    end
    chk("stall_hold", {63'd0, ok}, 64'd1);
    pix_adv = 1'b1;
    @(posedge clk);
    #1 pix_adv = 1'b0;
    chk("stall_resume", {47'd0, a1_x, pix_valid}, {47'd0, 16'd56, 1'b1});
    pos_x_in = 16'd999;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_start_ign", {46'd0, a1_x, busy, pix_valid},
        {46'd0, 16'd56, 2'b11});
    abort   = 1'b1;
    pix_adv = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    pix_adv = 1'b0;
    chk("abort_flags", {61'd0, pix_valid, busy, done}, 64'd0);
    chk("abort_ptr", {32'd0, a1_x, a1_y}, {32'd0, 16'd56, 16'd7});
    ok = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy || a1_x != 16'd56) ok = 0;
    end
    chk("abort_quiet", {63'd0, ok}, 64'd1);

    // zero inner count
    pos_x_in  = 16'd3;   pos_fx_in = 16'h1111;
    pos_y_in  = 16'd4;   pos_fy_in = 16'h2222;
    inner_cnt = 16'd0;   outer_cnt = 16'd5;
    pix_adv   = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("zero_ptr", {a1_x, a1_fx, a1_y, a1_fy},
        {16'd3, 16'h1111, 16'd4, 16'h2222});
    chk("zero_done", {61'd0, pix_valid, busy, done}, 64'd1);
    ok = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (pix_valid || busy || done) ok = 0;
    end
    chk("zero_after", {63'd0, ok}, 64'd1);
    pix_adv = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a1_ptr_step.md
# a1_ptr_step

A1 pointer stepper for the blitter address path. Holds the A1 window pointer as 16.16 fixed-point X and Y, and walks it across an inner (pixel) by outer (line) rectangle: it adds the pixel increment on each accepted pixel and the line step at the end of each line. Its integer outputs drive the A1 window comparator directly, which flags pixels outside the A1 window for clipping. It also tells the blitter's write sequencer which pointer is current and when the walk is finished.

## Interface
Parameters: none. All widths are fixed.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- resetl  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; loads the pointer and counts and begins a walk (accepted in IDLE only)
- abort  in  1  synchronous; returns the block to IDLE with no done pulse
- pos_x_in, pos_y_in  in  16 each  initial integer X/Y
- pos_fx_in, pos_fy_in  in  16 each  initial fraction X/Y
- inc_x, inc_y, inc_fx, inc_fy  in  16 each  per-pixel increment (integer, fraction); two's complement
- step_x, step_y, step_fx, step_fy  in  16 each  per-line step (integer, fraction); two's complement
- inner_cnt  in  16  pixels per line, sampled at start
- outer_cnt  in  16  number of lines, sampled at start
- pix_adv  in  1  consumer accepts the current pixel (qualified by pix_valid)
- a1_x, a1_y  out  16 each  integer pointer to the comparator; bit 15 is the sign bit
- a1_fx, a1_fy  out  16 each  fractional pointer
- pix_valid  out  1  the current pointer is a pixel to be processed
- busy  out  1  high from the cycle after an accepted start until the done cycle
- done  out  1  one-cycle pulse when a walk completes

## Operation
- The X and Y pointers are 32-bit values in {integer, fraction} form.
  - Every add is a full 32-bit two's-complement add: the fraction carries into the integer part.
  - Results wrap modulo 2^32. There is no saturation or clamping.
- States:
  - IDLE: busy=0, pix_valid=0. A start loads the pointer, icnt=inner_cnt, ocnt=outer_cnt.
    - Both counts nonzero: go to RUN.
    - Either count zero: go to FIN.
  - RUN: pix_valid=1. On pix_adv: pointer += inc, icnt -= 1.
    - If icnt was 1: go to LINE.
    - Without pix_adv: hold everything.
  - LINE: one cycle, pix_valid=0. pointer += step, icnt reloads with the sampled inner count, ocnt -= 1.
    - If ocnt was 1: go to FIN; otherwise return to RUN.
  - FIN: one cycle. done=1, busy=0; go to IDLE.
- The pointer keeps its final value in IDLE, so a new start is the only thing that changes it.
- start outside IDLE is ignored.
- abort has priority over everything except reset: any state goes to IDLE next cycle; pointer and counters hold; no done pulse.
- start and abort in the same cycle in IDLE: abort wins and start is ignored.
- pix_adv while pix_valid=0 is ignored.

## Timing
- Reset (resetl low, asynchronous):
  - State goes to IDLE.
  - All pointer and counter registers clear to 0, so a1_x, a1_y, a1_fx, a1_fy = 0.
  - pix_valid = busy = done = 0.
  - Release is synchronous to clk. Reset mid-walk discards the walk with no done pulse.
- start at edge N: the loaded pointer is visible and busy=1 after edge N. In RUN, pix_valid=1 in the same cycle.
- Pixel advance: pix_adv sampled high at edge N gives the updated pointer after edge N, i.e. a single-cycle update. Back-to-back pix_adv gives one pixel per clock.
- Line overhead: exactly one cycle (LINE) per line, including the last line.
- Walk of n×m pixels with pix_adv held high: from start to done takes 1 + n·m + m + 1 cycles.
- Zero-count start: done is asserted two cycles after start (IDLE→FIN→IDLE); pix_valid never rises.
- Outputs are registered; the comparator sees them with zero added latency.

## Test plan
- Reset values: hold resetl low mid-walk.
  - Required: all outputs read 0 immediately (asynchronously).
  - After release: IDLE, no done pulse.
- Simple 3×2 walk: pos=(10.0, 20.0), inc=(1.0, 0), step=(-3.0, 1.0), pix_adv held high.
  - Required a1_x sequence on pix_valid cycles: 10, 11, 12 then 10, 11, 12 with a1_y 20 then 21.
  - Required final pointer: (10, 22).
  - Required: done exactly 10 cycles after start.
- Fraction carry: pos_x = 0x0000.C000, inc = 0x0000.4000, 4×1 walk.
  - Required a1_x.a1_fx sequence: 0.C000, 1.0000, 1.4000, 1.8000; final value 1.C000.
- Negative wrap: pos_x = 0x0001.0000, inc = 0xFFFF.0000, 3×1 walk.
  - Required a1_x: 0x0001, 0x0000, 0xFFFF (bit 15 set).
- Stall, abort and ignored start:
  - Deassert pix_adv for 5 cycles during RUN. Required: pointer and counts hold, pix_valid stays 1.
  - Pulse start while busy. Required: ignored.
  - Then pulse abort. Required: IDLE next cycle, busy=0, no done pulse, pointer unchanged.
- Zero count: start with inner_cnt=0, outer_cnt=5.
  - Required: pointer loaded, pix_valid never asserted, done two cycles after start.
